// File: rtl/mips_mc_core.sv
// Multi-cycle 16-bit-instruction MIPS-like core: FETCH/DECODE/EXEC/MEM/WB with
// req/ack instruction and data ports and a terminal HALT state.
module mips_mc_core #(
    parameter int unsigned       XLEN     = 16,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic            halted
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    localparam logic [2:0] OpR    = 3'b000;
    localparam logic [2:0] OpSlti = 3'b001;
    localparam logic [2:0] OpJ    = 3'b010;
    localparam logic [2:0] OpJal  = 3'b011;
    localparam logic [2:0] OpLw   = 3'b100;
    localparam logic [2:0] OpSw   = 3'b101;
    localparam logic [2:0] OpBeq  = 3'b110;
    localparam logic [2:0] OpAddi = 3'b111;

    state_e          state_q;
    logic [XLEN-1:0] pc_q, npc_q, a_q, b_q, alu_q;
    logic [15:0]     ir_q;
    logic [XLEN-1:0] rf_q [8];

    logic [2:0]      op, rs, rt, rd, wb_dst;
    logic [3:0]      funct;
    logic [XLEN-1:0] simm, pc2, br_tgt, j_tgt;
    logic [XLEN-1:0] alu_res, exec_npc;
    state_e          exec_next;

    assign op     = ir_q[15:13];
    assign rs     = ir_q[12:10];
    assign rt     = ir_q[9:7];
    assign rd     = ir_q[6:4];
    assign funct  = ir_q[3:0];
    assign simm   = {{(XLEN-7){ir_q[6]}}, ir_q[6:0]};
    assign pc2    = pc_q + XLEN'(2);
    assign br_tgt = pc2 + (simm << 1);
    assign j_tgt  = {pc2[XLEN-1:14], ir_q[12:0], 1'b0};
    assign wb_dst = (op == OpR) ? rd : (op == OpJal) ? 3'd7 : rt;

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;

    always_comb begin
        alu_res   = '0;
        exec_npc  = pc2;
        exec_next = StFetch;
        case (op)
            OpR: begin
                case (funct)
                    4'd0: begin alu_res = a_q + b_q; exec_next = StWb; end
                    4'd1: begin alu_res = a_q - b_q; exec_next = StWb; end
                    4'd2: begin alu_res = a_q & b_q; exec_next = StWb; end
                    4'd3: begin alu_res = a_q | b_q; exec_next = StWb; end
                    4'd4: begin
                        alu_res   = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                        exec_next = StWb;
                    end
                    4'd8:    exec_npc  = a_q;
                    4'd15:   exec_next = StHalt;
                    default: ;
                endcase
            end
            OpSlti: begin
                alu_res   = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(simm)};
                exec_next = StWb;
            end
            OpJ:  exec_npc = j_tgt;
            OpJal: begin
                exec_npc  = j_tgt;
                alu_res   = pc2;
                exec_next = StWb;
            end
            OpLw, OpSw: exec_next = StMem;
            OpBeq: if (a_q == b_q) exec_npc = br_tgt;
            OpAddi: begin
                alu_res   = a_q + simm;
                exec_next = StWb;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            npc_q      <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_q      <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    // Request comes up one clock after reset release.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q     <= imem_rdata;
                        imem_req <= 1'b0;
                        state_q  <= StDecode;
                    end
                end
                StDecode: begin
                    a_q     <= rf_q[rs];
                    b_q     <= rf_q[rt];
                    state_q <= StExec;
                end
                StExec: begin
                    alu_q   <= alu_res;
                    npc_q   <= exec_npc;
                    state_q <= exec_next;
                    case (exec_next)
                        StFetch: begin
                            pc_q     <= exec_npc;
                            imem_req <= 1'b1;
                        end
                        StHalt: begin
                            pc_q   <= exec_npc;
                            halted <= 1'b1;
                        end
                        StMem: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OpSw);
                            dmem_addr  <= a_q + simm;
                            dmem_wdata <= b_q;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            pc_q     <= npc_q;
                            imem_req <= 1'b1;
                            state_q  <= StFetch;
                        end else begin
                            alu_q   <= dmem_rdata;
                            state_q <= StWb;
                        end
                    end
                end
                StWb: begin
                    if (wb_dst != 3'd0) rf_q[wb_dst] <= alu_q;
                    pc_q     <= npc_q;
                    imem_req <= 1'b1;
                    state_q  <= StFetch;
                end
                StHalt: ;
                default: state_q <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: a 16-bit core with wait-state memory models and a
// 32-bit core running a short program from a non-zero reset PC.
module tb_mips_mc_core;

    logic        clk, reset, reset32;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
    logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;

    logic        imem_req_w, imem_ack_w, dmem_req_w, dmem_we_w, dmem_ack_w, halted_w;
    logic [15:0] imem_rdata_w;
    logic [31:0] imem_addr_w, dmem_addr_w, dmem_wdata_w, dmem_rdata_w, pc_out_w;

    logic [15:0] imem [64];
    logic [15:0] dmem [64];
    logic [15:0] prog32 [8];
    int          ddelay, dcnt, cyc, nstores, n32_fetch, n32_stores;
    logic        stray;
    logic [31:0] st32_data;
    int          fetch_addr[$], fetch_cyc[$], req_len[$], st_addr[$], st_data[$];
    int          n_cmp, n_err;

    mips_mc_core #(.XLEN(16), .RESET_PC(16'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_out(pc_out), .halted(halted)
    );

    mips_mc_core #(.XLEN(32), .RESET_PC(32'h10)) dut32 (
        .clk(clk), .reset(reset32),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w),
        .imem_rdata(imem_rdata_w),
        .dmem_req(dmem_req_w), .dmem_we(dmem_we_w), .dmem_addr(dmem_addr_w),
        .dmem_wdata(dmem_wdata_w), .dmem_ack(dmem_ack_w), .dmem_rdata(dmem_rdata_w),
        .pc_out(pc_out_w), .halted(halted_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {3'b000, 3'(rs), 3'(rt), 3'(rd), 4'(fn)};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {3'(op), 3'(rs), 3'(rt), 7'(imm)};
    endfunction

    function automatic logic [15:0] enc_j(input int op, input int tgt);
        return {3'(op), 13'(tgt)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responders act on the falling edge; a handshake seen here completes on the next rise.
    initial begin
        imem_ack = 0; imem_rdata = '0; dmem_ack = 0; dmem_rdata = '0; dcnt = 0; cyc = 0;
        imem_ack_w = 0; imem_rdata_w = '0; dmem_ack_w = 0; dmem_rdata_w = '0;
        forever begin
            @(negedge clk);
            cyc++;
            imem_rdata = imem[imem_addr[6:1]];
            imem_ack   = imem_req;
            if (imem_req) begin
                fetch_addr.push_back(int'(imem_addr));
                fetch_cyc.push_back(cyc);
            end
            dcnt       = dmem_req ? dcnt + 1 : 0;
            dmem_rdata = dmem[dmem_addr[6:1]];
            dmem_ack   = (dmem_req && dcnt > ddelay) || stray;
            if (dmem_req && dmem_ack) begin
                req_len.push_back(dcnt);
                if (dmem_we) begin
                    dmem[dmem_addr[6:1]] = dmem_wdata;
                    nstores++;
                    st_addr.push_back(int'(dmem_addr));
                    st_data.push_back(int'(dmem_wdata));
                end
            end
            imem_rdata_w = prog32[imem_addr_w[3:1]];
            imem_ack_w   = imem_req_w;
            if (imem_req_w) n32_fetch++;
            dmem_ack_w = dmem_req_w;
            if (dmem_req_w && dmem_we_w) begin
                st32_data = dmem_wdata_w;
                n32_stores++;
            end
        end
    end

    task automatic apply_reset(input int delay);
        reset = 1'b1;
        stray = 1'b0;
        ddelay = delay;
        nstores = 0;
        for (int i = 0; i < 64; i++) dmem[i] = 16'hDEAD;
        fetch_addr.delete(); fetch_cyc.delete(); req_len.delete();
        st_addr.delete(); st_data.delete();
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) imem[i] = enc_r(0, 0, 0, 15);
    endtask

    task automatic wait_halt(input string tag, input int bound);
        int n;
        n = 0;
        while (!halted && n < bound) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(tag, 32'(halted), 32'd1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n32_fetch = 0; n32_stores = 0; st32_data = '0;
        reset = 1'b1; reset32 = 1'b1; stray = 1'b0; ddelay = 0;
        prog32[0] = enc_i(7, 0, 1, -1);
        prog32[1] = enc_r(1, 1, 1, 0);
        prog32[2] = enc_i(5, 0, 1, 0);
        for (int i = 3; i < 8; i++) prog32[i] = enc_r(0, 0, 0, 15);

        // addi/addi/add then store the sum; 4-cycle instructions
        clear_prog();
        imem[0] = enc_i(7, 0, 1, 5);
        imem[1] = enc_i(7, 0, 2, -3);
        imem[2] = enc_r(1, 2, 3, 0);
        imem[3] = enc_i(5, 0, 3, 0);
        apply_reset(0);
        check("rst_pc", 32'(pc_out), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc32", pc_out_w, 32'h10);
        reset = 1'b0; reset32 = 1'b0;
        @(negedge clk); #1;
        check("imem_req_after_release", 32'(imem_req), 32'd0);
        wait_halt("halt_t1", 100);
        check("t1_fetch_at_6", 32'(fetch_addr[3]), 32'd6);
        check("t1_lat_0", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd4);
        check("t1_lat_1", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd4);
        check("t1_lat_2", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd4);
        check("t1_r3", 32'(dmem[0]), 32'd2);
        check("t1_fetch_count", 32'(fetch_addr.size()), 32'd5);
        check("t1_no_req_halted", 32'(imem_req), 32'd0);

        // XLEN=32 core ran alongside
        check("x32_halted", 32'(halted_w), 32'd1);
        check("x32_r1", st32_data, 32'hFFFF_FFFE);
        check("x32_stores", 32'(n32_stores), 32'd1);
        check("x32_fetches", 32'(n32_fetch), 32'd4);
        check("x32_no_req", 32'(imem_req_w), 32'd0);

        // sw/lw with 3 wait cycles on the data port
        clear_prog();
        imem[0] = enc_i(7, 0, 1, 5);
        imem[1] = enc_i(5, 0, 1, 4);
        imem[2] = enc_i(4, 0, 4, 4);
        imem[3] = enc_i(5, 0, 4, 6);
        apply_reset(3);
        reset = 1'b0;
        wait_halt("halt_t2", 200);
        check("t2_sw_addr", 32'(st_addr[0]), 32'd4);
        check("t2_sw_data", 32'(st_data[0]), 32'd5);
        check("t2_sw_req_len", 32'(req_len[0]), 32'd4);
        check("t2_lw_req_len", 32'(req_len[1]), 32'd4);
        check("t2_r4", 32'(dmem[3]), 32'd5);
        check("t2_nstores", 32'(nstores), 32'd2);

        // ALU ops, signed compares, no-op funct, r0 write ignored
        clear_prog();
        imem[0]  = enc_i(7, 0, 1, 5);
        imem[1]  = enc_i(7, 0, 2, -3);
        imem[2]  = enc_r(1, 2, 3, 1);
        imem[3]  = enc_r(1, 2, 4, 2);
        imem[4]  = enc_r(1, 2, 5, 3);
        imem[5]  = enc_r(2, 1, 6, 4);
        imem[6]  = enc_i(1, 1, 7, -1);
        imem[7]  = enc_r(2, 2, 1, 5);
        imem[8]  = enc_r(1, 1, 0, 0);
        imem[9]  = enc_i(5, 0, 3, 0);
        imem[10] = enc_i(5, 0, 4, 2);
        imem[11] = enc_i(5, 0, 5, 4);
        imem[12] = enc_i(5, 0, 6, 6);
        imem[13] = enc_i(5, 0, 7, 8);
        imem[14] = enc_i(5, 0, 1, 10);
        imem[15] = enc_i(5, 0, 0, 12);
        apply_reset(1);
        reset = 1'b0;
        wait_halt("halt_t3", 400);
        check("t3_sub", 32'(dmem[0]), 32'h0008);
        check("t3_and", 32'(dmem[1]), 32'h0005);
        check("t3_or", 32'(dmem[2]), 32'hFFFD);
        check("t3_slt", 32'(dmem[3]), 32'h0001);
        check("t3_slti", 32'(dmem[4]), 32'h0000);
        check("t3_nop_funct", 32'(dmem[5]), 32'h0005);
        check("t3_r0", 32'(dmem[6]), 32'h0000);

        // j to 10, beq taken back to 8
        clear_prog();
        imem[0] = enc_i(7, 0, 1, 1);
        imem[1] = enc_j(2, 5);
        imem[5] = enc_i(6, 1, 1, -2);
        apply_reset(0);
        reset = 1'b0;
        wait_halt("halt_t4", 100);
        check("t4_j_target", 32'(fetch_addr[2]), 32'd10);
        check("t4_beq_taken", 32'(fetch_addr[3]), 32'd8);

        // beq not taken at 10 falls through to 12
        imem[5] = enc_i(6, 1, 0, -2);
        apply_reset(0);
        reset = 1'b0;
        wait_halt("halt_t5", 100);
        check("t5_beq_not_taken", 32'(fetch_addr[3]), 32'd12);

        // jal 0x20 from 4, store r7, jr r7
        clear_prog();
        imem[0]  = enc_r(0, 0, 0, 0);
        imem[1]  = enc_r(0, 0, 0, 5);
        imem[2]  = enc_j(3, 'h20);
        imem[32] = enc_i(5, 0, 7, 0);
        imem[33] = enc_r(7, 0, 0, 8);
        apply_reset(0);
        reset = 1'b0;
        wait_halt("halt_t6", 100);
        check("t6_jal_target", 32'(fetch_addr[3]), 32'h40);
        check("t6_r7", 32'(dmem[0]), 32'd6);
        check("t6_jr_target", 32'(fetch_addr[5]), 32'd6);

        // reset in the middle of a stalled store, then stray acks
        clear_prog();
        imem[0] = enc_i(7, 0, 1, 5);
        imem[1] = enc_i(5, 0, 1, 4);
        apply_reset(50);
        reset = 1'b0;
        begin
            int n;
            n = 0;
            while (!dmem_req && n < 60) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        check("t7_store_pending", 32'(dmem_req & dmem_we), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("t7_rst_dmem_req", 32'(dmem_req), 32'd0);
        check("t7_rst_pc", 32'(pc_out), 32'h0);
        check("t7_no_store", 32'(nstores), 32'd0);
        fetch_addr.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        stray = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        stray = 1'b0;
        ddelay = 0;
        check("t7_stray_ignored", 32'(nstores), 32'd0);
        wait_halt("halt_t7", 100);
        check("t7_refetch_0", 32'(fetch_addr[0]), 32'd0);
        check("t7_nstores", 32'(nstores), 32'd1);
        check("t7_store_data", 32'(dmem[2]), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 SHALL have parameter XLEN, default 16: datapath/register width, legal 16..32.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  instruction fetch request.
REQ-006 SHALL have port imem_addr  output  XLEN  byte address of the fetch.
REQ-007 SHALL have port imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-008 SHALL have port imem_rdata  input  16  instruction word.
REQ-009 SHALL have port dmem_req  output  1  data access request.
REQ-010 SHALL have port dmem_we  output  1  1 = store, 0 = load.
REQ-011 SHALL have port dmem_addr / dmem_wdata  output  XLEN each  access address / store data.
REQ-012 SHALL have port dmem_ack  input  1  access complete; dmem_rdata valid this cycle.
REQ-013 SHALL have port dmem_rdata  input  XLEN  load data.
REQ-014 SHALL have port pc_out  output  XLEN  current PC.
REQ-015 SHALL have port halted  output  1  core is in HALT.

Function
REQ-016 Fields SHALL be: op=[15:13], rs=[12:10], rt=[9:7], rd=[6:4], funct=[3:0], imm7=[6:0], jtgt=[12:0].
REQ-017 Opcodes SHALL be: 000 R-type, 001 slti, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi.
REQ-018 R-type funct SHALL be: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed), 8 jr, 15 halt; other functs SHALL be no-ops.
REQ-019 Register file SHALL hold 8 x XLEN registers; r0 SHALL read 0 and ignore writes.
REQ-020 imm7 SHALL be sign-extended to XLEN for addi/slti/lw/sw/beq; arithmetic SHALL wrap modulo 2^XLEN.
REQ-021 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-022 FETCH: hold imem_req=1, imem_addr=PC until imem_ack; latch IR; go to DECODE.
REQ-023 DECODE: latch A=R[rs], B=R[rt]; go to EXEC.
REQ-024 EXEC: compute ALU or next PC. Next state is MEM for lw/sw, WB for R-ALU/addi/slti/jal, HALT for halt, and FETCH for j/jr/beq/no-op.
REQ-025 Next PC SHALL be: PC+2 by default; beq taken (A==B) PC+2+(simm7<<1); j and jal {PC+2[XLEN-1:14], jtgt, 0}; jr A.
REQ-026 PC SHALL update on EXEC exit, except for lw/sw and WB-bound instructions, where it updates on that instruction's final state.
REQ-027 MEM: hold dmem_req=1, dmem_we, dmem_addr=A+simm7, dmem_wdata=B until dmem_ack; lw goes to WB, sw goes to FETCH.
REQ-028 WB: write rd (R-type), rt (addi/slti/lw), or r7=PC+2 (jal); go to FETCH.
REQ-029 Instruction latency SHALL be 3 + memory-wait cycles plus 1 for each of MEM and WB when used; wait states are unbounded.
REQ-030 imem_req and dmem_req SHALL never be asserted together; their address/data SHALL remain stable while the request is held.
REQ-031 HALT SHALL be left only by reset; halted=1 only in HALT.
REQ-032 An ack received when no request is outstanding SHALL be ignored.

Reset
REQ-033 reset SHALL asynchronously force: state FETCH, PC=RESET_PC, all registers 0, IR 0, imem_req 0 until the first clock after release, dmem_req 0, dmem_we 0, halted 0.
REQ-034 Reset asserted mid-access SHALL abandon the access with no register or PC side effects; a late ack is ignored under REQ-032.

Verification
REQ-035 addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2, all with zero-wait acks -> r3=2; each instruction takes 4 cycles; PC=6.
REQ-036 sw r1,[r0+4] then lw r4,[r0+4], with dmem_ack delayed 3 cycles -> dmem_addr=4, dmem_wdata=5, r4=5; dmem_req is held for 4 cycles each.
REQ-037 beq r1,r1,-2 at PC=10 -> next PC=8; beq not taken -> next PC=12.
REQ-038 jal 0x20 at PC=4 -> r7=6, PC=0x40; then jr r7 -> PC=6.
REQ-039 XLEN=32 with addi r1,r0,-1 followed by add r1,r1,r1 -> r1=0xFFFFFFFE; halt -> halted=1, no further imem_req.
REQ-040 reset pulsed while dmem_req=1 for a store -> no memory write is counted, PC=RESET_PC, fetch restarts, and a stray dmem_ack is ignored.
